// File: rtl/fourhundred_gbe_pkg.sv
// Shared types for the 400G transmit path: AXIS beat layout, packet RAM word
// packing and the packet-buffer write FSM encoding.
package fourhundred_gbe_pkg;

  localparam int unsigned AXIS_DATA_W = 1024;
  localparam int unsigned AXIS_KEEP_W = 128;
  localparam int unsigned PKT_RAM_W   = AXIS_DATA_W + AXIS_KEEP_W + 2;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic                   tuser;
  } axis_tx_pkt_t;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

  // tvalid is not stored; the RAM word is {tdata, tkeep, tlast, tuser}
  function automatic logic [PKT_RAM_W-1:0] pkt_pack(input axis_tx_pkt_t p);
    return {p.tdata, p.tkeep, p.tlast, p.tuser};
  endfunction

  function automatic axis_tx_pkt_t pkt_unpack(input logic [PKT_RAM_W-1:0] w, input logic vld);
    axis_tx_pkt_t p;
    p.tdata  = w[PKT_RAM_W-1 -: AXIS_DATA_W];
    p.tkeep  = w[2 +: AXIS_KEEP_W];
    p.tlast  = w[1];
    p.tuser  = w[0];
    p.tvalid = vld;
    return p;
  endfunction

endpackage

// File: rtl/axis_pkt_ram.sv
// Simple dual-port packet RAM: one write port, one registered read port,
// no reset on the storage array.
module axis_pkt_ram
  import fourhundred_gbe_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [PKT_RAM_W-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [PKT_RAM_W-1:0] rdata
);

  logic [PKT_RAM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_tx_pkt_buffer.sv
// Store-and-forward AXIS packet buffer: frames are released downstream only
// once fully stored; oversized, overflowing and bad frames are dropped whole.
module axis_tx_pkt_buffer
  import fourhundred_gbe_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter bit          DROP_BAD_FRAME = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [31:0]            pkt_cnt,
  output logic [31:0]            drop_cnt,
  output logic                   drop_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wr_state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, raddr_q;
  logic [31:0]   pkt_cnt_q, drop_cnt_q;
  logic          drop_pulse_q, tready_q, ram_vld_q;
  logic          acc, full, bad, we, commit, drop;
  logic          pop, issue;
  logic [1:0]    occ;
  axis_tx_pkt_t  s_beat, ram_beat, s0_q, s0_d, s1_q, s1_d;
  logic [PKT_RAM_W-1:0] ram_wdata, ram_rdata;

  assign s_beat = '{tdata: s_axis_tdata, tvalid: s_axis_tvalid, tkeep: s_axis_tkeep,
                    tlast: s_axis_tlast, tuser: s_axis_tuser};
  assign ram_wdata = pkt_pack(s_beat);
  assign ram_beat  = pkt_unpack(ram_rdata, ram_vld_q);

  assign acc  = s_axis_tvalid && tready_q;
  assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign bad  = DROP_BAD_FRAME && s_axis_tlast && s_axis_tuser;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    we          = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (full) begin
            if (s_axis_tlast) drop = 1'b1;
            else              state_d = DROP;
          end else if (bad) begin
            drop = 1'b1;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_tlast) begin
              commit      = 1'b1;
              wr_commit_d = wr_ptr_q + PW'(1);
            end else begin
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          // Overflow and bad-frame both roll the partial frame back
          if (full || bad) begin
            wr_ptr_d = wr_commit_q;
            if (s_axis_tlast) begin
              drop    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_tlast) begin
              commit      = 1'b1;
              wr_commit_d = wr_ptr_q + PW'(1);
              state_d     = IDLE;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            drop    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // raddr_q runs ahead into the RAM/skid pipeline; rd_ptr_q only advances on
  // the output handshake, so prefetched beats still count as occupied space.
  assign pop   = s0_q.tvalid && m_axis_tready;
  assign occ   = {1'b0, s0_q.tvalid} + {1'b0, s1_q.tvalid} + {1'b0, ram_vld_q} - {1'b0, pop};
  assign issue = (raddr_q != wr_commit_q) && (occ < 2'd2);

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    unique case ({pop, ram_vld_q})
      2'b01: begin
        if (!s0_q.tvalid) s0_d = ram_beat;
        else              s1_d = ram_beat;
      end
      2'b10: begin
        s0_d        = s1_q;
        s1_d.tvalid = 1'b0;
      end
      2'b11: begin
        if (s1_q.tvalid) begin
          s0_d = s1_q;
          s1_d = ram_beat;
        end else begin
          s0_d = ram_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      raddr_q      <= '0;
      ram_vld_q    <= 1'b0;
      s0_q         <= '0;
      s1_q         <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_q + PW'(pop);
      raddr_q      <= raddr_q + PW'(issue);
      ram_vld_q    <= issue;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      pkt_cnt_q    <= pkt_cnt_q + 32'(commit);
      drop_cnt_q   <= drop_cnt_q + 32'(drop);
      drop_pulse_q <= drop;
      tready_q     <= 1'b1;
    end
  end

  axis_pkt_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (ram_wdata),
    .re    (issue),
    .raddr (raddr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = s0_q.tvalid;
  assign m_axis_tdata  = s0_q.tdata;
  assign m_axis_tkeep  = s0_q.tkeep;
  assign m_axis_tlast  = s0_q.tlast;
  assign m_axis_tuser  = DROP_BAD_FRAME ? 1'b0 : s0_q.tuser;
  assign fill_level    = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_axis_tx_pkt_buffer.sv
// Bench for axis_tx_pkt_buffer: frame table plus hand-built overflow, bad-frame
// and mid-frame reset sequences, with a scoreboard on the output stream.
module tb_axis_tx_pkt_buffer;

  typedef struct {
    logic [1023:0] d;
    logic [127:0]  k;
    logic          l;
    logic          u;
  } beat_t;

  typedef struct {
    int len;
    bit bad_fr;
    int rmode;
    int exp_pkt;
    int exp_drop;
    bit drain;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1023:0] s_tdata = '0, m_tdata;
  logic [127:0]  s_tkeep = '0, m_tkeep;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, s_tready;
  logic          m_tvalid, m_tlast, m_tuser, dpulse;
  logic          m_tready = 1'b0;
  logic [8:0]    fill;
  logic [31:0]   pkt, drop;

  logic [1023:0] s1_tdata = '0, m1_tdata;
  logic [127:0]  s1_tkeep = '0, m1_tkeep;
  logic          s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0, s1_tready;
  logic          m1_tvalid, m1_tlast, m1_tuser, dpulse1;
  logic          m1_tready = 1'b1;
  logic [4:0]    fill1;
  logic [31:0]   pkt1, drop1;

  axis_tx_pkt_buffer #(.DEPTH(256), .DROP_BAD_FRAME(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .fill_level(fill), .pkt_cnt(pkt), .drop_cnt(drop), .drop_pulse(dpulse)
  );

  axis_tx_pkt_buffer #(.DEPTH(16), .DROP_BAD_FRAME(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tvalid(s1_tvalid),
    .s_axis_tready(s1_tready), .s_axis_tlast(s1_tlast), .s_axis_tuser(s1_tuser),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
    .m_axis_tready(m1_tready), .m_axis_tlast(m1_tlast), .m_axis_tuser(m1_tuser),
    .fill_level(fill1), .pkt_cnt(pkt1), .drop_cnt(drop1), .drop_pulse(dpulse1)
  );

  int    n_total = 0;
  int    n_bad   = 0;
  int    rmode   = 0;
  bit    in_frame = 1'b0;
  beat_t sb[$];
  beat_t cap1[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got low64 %h expected low64 %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic beat_t gen_beat(input bit last, input bit user);
    beat_t b;
    logic [127:0] k = '1;
    for (int w = 0; w < 32; w++) b.d[w*32 +: 32] = $urandom;
    b.k = last ? (k >> $urandom_range(0, 127)) : k;
    b.l = last;
    b.u = user;
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    s_tdata  = b.d;
    s_tkeep  = b.k;
    s_tlast  = b.l;
    s_tuser  = b.u;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int len, input bit bad_fr, input bit pass);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b = gen_beat(j == len - 1, bad_fr && (j == len - 1));
      if (pass) begin
        beat_t e;
        e = b;
        e.u = 1'b0;
        sb.push_back(e);
      end
      drive_beat(b);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while ((sb.size() != 0 || fill != 0 || m_tvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_drained"}, n < 3000, 1);
    check({nm, "_fill0"}, fill, 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (in_frame && m_tready) check("no_bubble", m_tvalid, 1);
      if (m_tvalid && m_tready) begin
        n_total++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got beat low64 %h expected none", m_tdata[63:0]);
        end else begin
          beat_t e;
          n_total--;
          e = sb.pop_front();
          chk_data("out_data", m_tdata, e.d);
          check("out_keep", m_tkeep, e.k);
          check("out_last_user", {m_tlast, m_tuser}, {e.l, e.u});
          in_frame = !e.l;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m1_tvalid && m1_tready) begin
      beat_t c;
      c.d = m1_tdata; c.k = m1_tkeep; c.l = m1_tlast; c.u = m1_tuser;
      cap1.push_back(c);
    end
  end

  initial begin
    vec_t  tbl[8];
    beat_t b;
    beat_t exp1[$];
    int    prev_drop;

    tbl[0] = '{1,   0, 2, 2, 0, 0};
    tbl[1] = '{64,  0, 2, 3, 0, 0};
    tbl[2] = '{1,   0, 2, 4, 0, 0};
    tbl[3] = '{64,  0, 2, 5, 0, 0};
    tbl[4] = '{300, 0, 2, 5, 1, 1};
    tbl[5] = '{2,   0, 2, 6, 1, 0};
    tbl[6] = '{3,   1, 2, 6, 2, 0};
    tbl[7] = '{4,   0, 1, 7, 2, 1};

    // reset state
    #21;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    chk_data("rst_m_tdata", m_tdata, '0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_last_user", {m_tlast, m_tuser}, 0);
    check("rst_fill", fill, 0);
    check("rst_pkt", pkt, 0);
    check("rst_drop", drop, 0);
    check("rst_pulse", dpulse, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_rst", s_tready, 1);

    // single 4-beat frame, latency
    rmode = 1;
    @(posedge clk); #1;
    send_frame(4, 0, 1);
    check("lat_e0", m_tvalid, 0);
    @(posedge clk); #1;
    check("lat_e1", m_tvalid, 0);
    @(posedge clk); #1;
    check("lat_e2", m_tvalid, 1);
    check("single_pkt", pkt, 1);
    wait_empty("single");

    // frame table
    prev_drop = 0;
    for (int i = 0; i < 8; i++) begin
      rmode = tbl[i].rmode;
      send_frame(tbl[i].len, tbl[i].bad_fr, tbl[i].exp_drop == prev_drop);
      check($sformatf("v%0d_pkt", i), pkt, tbl[i].exp_pkt);
      check($sformatf("v%0d_drop", i), drop, tbl[i].exp_drop);
      check($sformatf("v%0d_pulse", i), dpulse, tbl[i].exp_drop != prev_drop);
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_clr", i), dpulse, 0);
      if (tbl[i].drain) wait_empty($sformatf("v%0d", i));
      prev_drop = tbl[i].exp_drop;
    end

    // overflow with rollback to committed frames
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int f = 0; f < 5; f++) send_frame(50, 0, 1);
    check("ovf_fill250", fill, 250);
    check("ovf_pkt_pre", pkt, 12);
    for (int k = 1; k <= 10; k++) begin
      b = gen_beat(k == 10, 0);
      drive_beat(b);
      if (k == 6) check("ovf_fill256", fill, 256);
      if (k == 7) check("ovf_rollback", fill, 250);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("ovf_pulse", dpulse, 1);
    check("ovf_drop", drop, 3);
    check("ovf_fill_after", fill, 250);
    rmode = 1;
    wait_empty("ovf");
    check("ovf_pkt_post", pkt, 12);

    // tuser passthrough when bad frames are kept
    for (int j = 0; j < 3; j++) begin
      b = gen_beat(j == 2, j == 2);
      exp1.push_back(b);
      s1_tdata = b.d; s1_tkeep = b.k; s1_tlast = b.l; s1_tuser = b.u; s1_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s1_tvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("u1_beats", cap1.size(), 3);
    for (int j = 0; j < 3 && j < cap1.size(); j++) begin
      chk_data($sformatf("u1_data%0d", j), cap1[j].d, exp1[j].d);
      check($sformatf("u1_keep%0d", j), cap1[j].k, exp1[j].k);
      check($sformatf("u1_last_user%0d", j), {cap1[j].l, cap1[j].u}, {exp1[j].l, exp1[j].u});
    end
    check("u1_pkt", pkt1, 1);
    check("u1_drop", drop1, 0);
    check("u1_fill", fill1, 0);
    check("u1_tready", s1_tready, 1);

    // reset during beat 2 of a 5-beat frame while another frame is committed
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(3, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("prerst_tvalid", m_tvalid, 1);
    drive_beat(gen_beat(0, 0));
    b = gen_beat(0, 0);
    s_tdata = b.d; s_tkeep = b.k; s_tlast = 1'b0; s_tvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tready", s_tready, 0);
    chk_data("arst_tdata", m_tdata, '0);
    check("arst_fill", fill, 0);
    check("arst_pkt", pkt, 0);
    check("arst_drop", drop, 0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    in_frame = 1'b0;
    rmode = 1;
    @(posedge clk); #1;
    check("postrst_tready", s_tready, 1);
    send_frame(2, 0, 1);
    wait_empty("postrst");
    check("postrst_pkt", pkt, 1);
    check("postrst_drop", drop, 0);

    check("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
